// File: rtl/rv32_mod_branch_unit_if.sv
// rv32_mod_branch_unit_if: fetch prediction and execute resolution signals of the branch unit
interface rv32_mod_branch_unit_if #(
   parameter int XLEN = 32
);
   logic            pred_req;
   logic [XLEN-1:0] pred_pc;
   logic            pred_ack;
   logic            pred_taken;
   logic            ex_valid;
   logic [XLEN-1:0] ex_pc;
   logic [XLEN-1:0] rf_read0;
   logic [XLEN-1:0] rf_read1;
   logic [2:0]      cond;
   logic            is_cond;
   logic            is_jmp;
   logic            ex_pred_taken;
   logic            branch_taken;
   logic            cond_illegal;
   logic            mispredict;
   modport master (
      output pred_req, pred_pc, ex_valid, ex_pc, rf_read0, rf_read1, cond, is_cond, is_jmp, ex_pred_taken,
      input  pred_ack, pred_taken, branch_taken, cond_illegal, mispredict
   );
   modport slave (
      input  pred_req, pred_pc, ex_valid, ex_pc, rf_read0, rf_read1, cond, is_cond, is_jmp, ex_pred_taken,
      output pred_ack, pred_taken, branch_taken, cond_illegal, mispredict
   );
endinterface

// File: rtl/rv32_mod_branch_unit.sv
// rv32_mod_branch_unit: branch resolution, BHT prediction and mispredict flush; BRANCH_STATS_EN adds stat counters
module rv32_mod_branch_unit #(
   parameter int XLEN        = 32,
   parameter int BHT_ENTRIES = 64,
   parameter int CNT_BITS    = 2,
   parameter int PC_LSB      = 1
) (
   input  logic                  clk,
   input  logic                  rst,
`ifdef BRANCH_STATS_EN
   output logic [31:0]           stat_branches,
   output logic [31:0]           stat_mispredicts,
`endif
   rv32_mod_branch_unit_if.slave bus
);
   localparam int IDX_W = $clog2(BHT_ENTRIES);
   localparam logic [CNT_BITS-1:0] WNT = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
   localparam logic [CNT_BITS-1:0] MAX = '1;

   logic [CNT_BITS-1:0] bht [BHT_ENTRIES];
   logic                satisfied, upd, accepted, mis_next, pred_msb;
   logic [IDX_W-1:0]    upd_idx, pred_idx;
   logic [CNT_BITS-1:0] cur, nxt;
   logic                unused;

   assign unused = ^{bus.pred_pc, bus.ex_pc};

   // condition decode, resolution, counter update value and write-first prediction read
   always_comb begin
      satisfied = bus.cond[2]
         ? ((bus.cond[1] ? (bus.rf_read0 < bus.rf_read1)
                         : ($signed(bus.rf_read0) < $signed(bus.rf_read1))) ^ bus.cond[0])
         : (~bus.cond[1] & ((bus.rf_read0 == bus.rf_read1) ^ bus.cond[0]));
      bus.cond_illegal = bus.ex_valid & bus.is_cond & ~bus.is_jmp & (bus.cond[2:1] == 2'b01);
      bus.branch_taken = bus.ex_valid & (bus.is_jmp | (bus.is_cond & satisfied));
      upd = bus.ex_valid & bus.is_cond & ~bus.is_jmp & ~bus.cond_illegal;
      accepted = upd | (bus.ex_valid & bus.is_jmp);
      mis_next = upd ? (bus.branch_taken != bus.ex_pred_taken)
                     : (bus.ex_valid & bus.is_jmp & ~bus.ex_pred_taken);
      upd_idx = bus.ex_pc[PC_LSB +: IDX_W];
      pred_idx = bus.pred_pc[PC_LSB +: IDX_W];
      cur = bht[upd_idx];
      nxt = bus.branch_taken ? ((cur == MAX) ? cur : cur + 1'b1)
                             : ((cur == '0) ? cur : cur - 1'b1);
      pred_msb = (upd && upd_idx == pred_idx) ? nxt[CNT_BITS-1] : bht[pred_idx][CNT_BITS-1];
   end

   // BHT training plus registered prediction and mispredict pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= WNT;
         bus.pred_ack   <= 1'b0;
         bus.pred_taken <= 1'b0;
         bus.mispredict <= 1'b0;
      end else begin
         if (upd) bht[upd_idx] <= nxt;
         bus.pred_ack   <= bus.pred_req;
         bus.pred_taken <= bus.pred_req & pred_msb;
         bus.mispredict <= mis_next;
      end
   end

`ifdef BRANCH_STATS_EN
   // saturating resolution and mispredict counters, aligned with the mispredict pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else begin
         if (accepted && stat_branches != '1) stat_branches <= stat_branches + 32'd1;
         if (mis_next && stat_mispredicts != '1) stat_mispredicts <= stat_mispredicts + 32'd1;
      end
   end
`else
   logic unused_acc;
   assign unused_acc = accepted;
`endif
endmodule

// File: tb/tb_rv32_mod_branch_unit.sv
// tb_rv32_mod_branch_unit: random and directed checks of the branch unit against a behavioural model
module tb_rv32_mod_branch_unit;
   localparam int ENT = 64;
   localparam int CB  = 2;
   localparam int MAXV = (1 << CB) - 1;
   localparam int WNTV = (1 << (CB - 1)) - 1;

   logic clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   errors = 0;

   rv32_mod_branch_unit_if #(.XLEN(32)) bus ();
`ifdef BRANCH_STATS_EN
   logic [31:0] sb, sm;
   rv32_mod_branch_unit dut (.clk(clk), .rst(rst), .stat_branches(sb), .stat_mispredicts(sm), .bus(bus));
`else
   rv32_mod_branch_unit dut (.clk(clk), .rst(rst), .bus(bus));
`endif

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit sat(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
      case (c)
         3'd0: return a == b;
         3'd1: return a != b;
         3'd4: return $signed(a) < $signed(b);
         3'd5: return $signed(a) >= $signed(b);
         3'd6: return a < b;
         3'd7: return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   int m [ENT];
   bit have = 0;
   bit exp_ack, exp_pt, exp_mis;

   // reference model: checks last edge's registered outputs, the live combinational outputs, then advances
   always @(negedge clk) begin
      bit bt, ill, upd;
      int ui, pi;
      if (have) begin
         chk("pred_ack", bus.pred_ack, exp_ack);
         chk("pred_taken", bus.pred_taken, exp_pt);
         chk("mispredict", bus.mispredict, exp_mis);
      end
      ill = bus.ex_valid && bus.is_cond && !bus.is_jmp && (bus.cond == 3'd2 || bus.cond == 3'd3);
      bt  = bus.ex_valid && (bus.is_jmp || (bus.is_cond && sat(bus.rf_read0, bus.rf_read1, bus.cond)));
      chk("cond_illegal", bus.cond_illegal, ill);
      chk("branch_taken", bus.branch_taken, bt);
      if (rst) begin
         for (int i = 0; i < ENT; i++) m[i] = WNTV;
         exp_ack = 0; exp_pt = 0; exp_mis = 0; have = 1;
      end else if (have) begin
         upd = bus.ex_valid && bus.is_cond && !bus.is_jmp && !ill;
         ui = (bus.ex_pc / 2) % ENT;
         pi = (bus.pred_pc / 2) % ENT;
         if (upd) m[ui] = bt ? ((m[ui] < MAXV) ? m[ui] + 1 : MAXV) : ((m[ui] > 0) ? m[ui] - 1 : 0);
         exp_mis = upd ? (bt != bus.ex_pred_taken) : (bus.ex_valid && bus.is_jmp && !bus.ex_pred_taken);
         exp_ack = bus.pred_req;
         exp_pt  = bus.pred_req && (m[pi] > WNTV);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ex(input bit v, input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                     input logic [2:0] c, input bit ic, input bit ij, input bit ept);
      bus.ex_valid = v; bus.ex_pc = pc; bus.rf_read0 = a; bus.rf_read1 = b;
      bus.cond = c; bus.is_cond = ic; bus.is_jmp = ij; bus.ex_pred_taken = ept;
   endtask

   task automatic pr(input bit req, input logic [31:0] pc);
      bus.pred_req = req; bus.pred_pc = pc;
   endtask

   task automatic idle();
      ex(0, 0, 0, 0, 0, 0, 0, 0);
      pr(0, 0);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 4))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      rst = 1'b1;
      idle();
      tick(); tick();
      rst = 1'b0;
      // reset-state prediction
      pr(1, 32'h100); tick();
      chk("t1_ack", bus.pred_ack, 1);
      chk("t1_taken", bus.pred_taken, 0);
      idle();
      // condition sweep
      ex(1, 32'h40, 32'hFFFF_FFFF, 1, 3'b100, 1, 0, 0); #1 chk("t2_lt", bus.branch_taken, 1); tick();
      ex(1, 32'h40, 32'hFFFF_FFFF, 1, 3'b110, 1, 0, 0); #1 chk("t2_ltu", bus.branch_taken, 0); tick();
      ex(1, 32'h40, 32'hFFFF_FFFF, 1, 3'b101, 1, 0, 0); #1 chk("t2_ge", bus.branch_taken, 0); tick();
      ex(1, 32'h40, 32'hFFFF_FFFF, 1, 3'b111, 1, 0, 0); #1 chk("t2_geu", bus.branch_taken, 1); tick();
      ex(1, 32'h40, 32'h1234, 32'h1234, 3'b000, 1, 0, 0); #1 chk("t2_eq", bus.branch_taken, 1); tick();
      ex(1, 32'h40, 32'h1234, 32'h1234, 3'b001, 1, 0, 0); #1 chk("t2_ne", bus.branch_taken, 0); tick();
      ex(0, 32'h40, 32'h1234, 32'h1234, 3'b000, 1, 0, 0); #1 chk("t2_invalid", bus.branch_taken, 0); tick();
      // training and saturation at index 0
      ex(1, 32'h200, 5, 5, 3'b000, 1, 0, 1); tick(); tick();
      idle(); pr(1, 32'h200); tick();
      chk("t3_two_taken", bus.pred_taken, 1);
      idle(); ex(1, 32'h200, 5, 5, 3'b000, 1, 0, 1); tick();
      ex(1, 32'h200, 5, 5, 3'b001, 1, 0, 0); tick();
      idle(); pr(1, 32'h280); tick();
      chk("t3_sat_high", bus.pred_taken, 1);
      idle(); ex(1, 32'h200, 5, 5, 3'b001, 1, 0, 0); tick(); tick(); tick();
      idle(); pr(1, 32'h280); tick();
      chk("t3_floor", bus.pred_taken, 0);
      idle(); ex(1, 32'h200, 5, 5, 3'b000, 1, 0, 0); tick();
      idle(); pr(1, 32'h200); tick();
      chk("t3_no_wrap", bus.pred_taken, 0);
      // mispredict pulse
      idle(); ex(1, 32'h300, 7, 7, 3'b000, 1, 0, 0); tick();
      chk("t4_pulse", bus.mispredict, 1);
      idle(); tick();
      chk("t4_pulse_end", bus.mispredict, 0);
      ex(1, 32'h300, 0, 0, 3'b000, 1, 1, 1); #1 chk("t4_jmp_taken", bus.branch_taken, 1); tick();
      chk("t4_jmp_ok", bus.mispredict, 0);
      ex(1, 32'h300, 7, 7, 3'b010, 1, 0, 1); #1
      chk("t4_illegal", bus.cond_illegal, 1);
      chk("t4_illegal_bt", bus.branch_taken, 0);
      tick();
      chk("t4_illegal_mis", bus.mispredict, 0);
      // write-first collision at index 5
      ex(1, 32'hA, 3, 3, 3'b000, 1, 0, 1); pr(1, 32'hA); tick();
      chk("t5_bypass", bus.pred_taken, 1);
      ex(1, 32'hA, 3, 3, 3'b000, 1, 0, 0); pr(1, 32'hA); rst = 1'b1; tick();
      rst = 1'b0;
      chk("t5_rst_mis", bus.mispredict, 0);
      chk("t5_rst_ack", bus.pred_ack, 0);
      idle(); pr(1, 32'hA); tick();
      chk("t5_rst_wnt", bus.pred_taken, 0);
      idle();
      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 199) == 0);
         ex($urandom_range(0, 3) != 0, {24'h0, 8'($urandom)}, pick(), pick(), 3'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, 1'($urandom));
         pr(1'($urandom), {24'h0, 8'($urandom)});
         tick();
      end
      rst = 1'b0; idle(); tick();
`ifdef BRANCH_STATS_EN
      rst = 1'b1; tick(); rst = 1'b0;
      for (int n = 0; n < 5; n++) begin
         ex(1, 32'h20, 9, 9, 3'b000, 1, 0, n >= 3 ? 1'b0 : 1'b1);
         tick();
      end
      idle(); tick();
      chk("t6_branches", sb, 5);
      chk("t6_mispredicts", sm, 2);
      force dut.stat_branches = 32'hFFFF_FFFE;
      force dut.stat_mispredicts = 32'hFFFF_FFFE;
      #1;
      release dut.stat_branches;
      release dut.stat_mispredicts;
      ex(1, 32'h20, 0, 0, 3'b000, 0, 1, 0); tick(); tick(); tick();
      idle(); tick();
      chk("t6_sat_branches", sb, 32'hFFFF_FFFF);
      chk("t6_sat_mispredicts", sm, 32'hFFFF_FFFF);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("t6_rst_branches", sb, 0);
      chk("t6_rst_mispredicts", sm, 0);
      idle(); tick();
`endif
      tick();
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end
endmodule
